// File: rtl/bht_update_queue_pkg.sv
// Shared types and constants for the branch-predictor update queue.
// An entry is one resolved conditional branch: {pc, taken}.
package bht_update_queue_pkg;

  localparam int BR_ENTRY_W = 33;
  localparam int BHT_IDX_HI = 8;
  localparam int BHT_IDX_LO = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } br_entry_t;

  function automatic logic [31:0] redirect_target(input logic taken,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/bht_update_queue_if.sv
// Commit-side and BHT-side signal bundle of bht_update_queue.
// slave is the queue itself; master is whoever drives the commits.
interface bht_update_queue_if;
  logic        rdy;
  logic        c0_valid, c0_is_br, c0_taken, c0_pred;
  logic [31:0] c0_pc, c0_target;
  logic        c1_valid, c1_is_br, c1_taken, c1_pred;
  logic [31:0] c1_pc, c1_target;
  logic        commit_ready;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count, mp_count;
  logic        overflow;

  modport master (
    output rdy,
    output c0_valid, c0_is_br, c0_taken, c0_pred, c0_pc, c0_target,
    output c1_valid, c1_is_br, c1_taken, c1_pred, c1_pc, c1_target,
    input  commit_ready, upd_valid, upd_taken, upd_pc,
    input  mispredict, redirect_pc, br_count, mp_count, overflow
  );

  modport slave (
    input  rdy,
    input  c0_valid, c0_is_br, c0_taken, c0_pred, c0_pc, c0_target,
    input  c1_valid, c1_is_br, c1_taken, c1_pred, c1_pc, c1_target,
    output commit_ready, upd_valid, upd_taken, upd_pc,
    output mispredict, redirect_pc, br_count, mp_count, overflow
  );
endinterface

// File: rtl/bht_update_queue_dual_push_fifo.sv
// Circular buffer with up to two writes and one read per cycle, plus occupancy count.
// Caller guarantees it never writes more than the free space; second write implies first.
module dual_push_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int W     = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr0_vld,
  input  logic [W-1:0]     i_wr0_dat,
  input  logic             i_wr1_vld,
  input  logic [W-1:0]     i_wr1_dat,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [PTR_W:0]   o_count
);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wp1;

  assign w_wp1 = r_wp + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= r_wp + PTR_W'(i_wr0_vld) + PTR_W'(i_wr1_vld);
      r_rp    <= r_rp + PTR_W'(i_pop);
      r_count <= r_count + CNT_W'(i_wr0_vld) + CNT_W'(i_wr1_vld) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr0_vld) r_mem[r_wp]  <= i_wr0_dat;
    if (i_wr1_vld) r_mem[w_wp1] <= i_wr1_dat;
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_count;
endmodule

// File: rtl/bht_update_queue.sv
// Filters two in-order commit lanes down to conditional branches, flags mispredicts,
// and drains resolved {pc, taken} updates to the BHT one per cycle.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  bht_update_queue_if.slave   bus
);
  localparam int CNT_W = PTR_W + 1;

  logic             w_att0, w_att1, w_mp0, w_mp1;
  logic             w_commit_ready, w_pop, w_push0, w_push1;
  br_entry_t        w_dat0, w_dat1, w_head;
  logic [CNT_W-1:0] w_count, w_free;

  logic             r_upd_valid, r_upd_taken, r_mispredict, r_overflow;
  logic [31:0]      r_upd_pc, r_redirect_pc, r_br_count, r_mp_count;

  // A lane-0 mispredict makes lane 1 wrong-path, so it must not even be counted.
  assign w_att0 = bus.rdy & bus.c0_valid & bus.c0_is_br;
  assign w_mp0  = w_att0 & (bus.c0_taken != bus.c0_pred);
  assign w_att1 = bus.rdy & bus.c1_valid & bus.c1_is_br & ~w_mp0;
  assign w_mp1  = w_att1 & (bus.c1_taken != bus.c1_pred);

  assign w_free         = CNT_W'(DEPTH) - w_count;
  assign w_commit_ready = (w_free >= CNT_W'(2));

  // Compact the surviving lanes so a lone lane 1 lands in the next free slot.
  assign w_push0 = (w_att0 | w_att1) & w_commit_ready;
  assign w_push1 = w_att0 & w_att1 & w_commit_ready;
  assign w_dat0  = w_att0 ? br_entry_t'{pc: bus.c0_pc, taken: bus.c0_taken}
                          : br_entry_t'{pc: bus.c1_pc, taken: bus.c1_taken};
  assign w_dat1  = br_entry_t'{pc: bus.c1_pc, taken: bus.c1_taken};
  assign w_pop   = bus.rdy & (w_count != '0);

  dual_push_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (BR_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr0_vld (w_push0),
    .i_wr0_dat (w_dat0),
    .i_wr1_vld (w_push1),
    .i_wr1_dat (w_dat1),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_valid   <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_taken   <= 1'b0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_br_count    <= '0;
      r_mp_count    <= '0;
      r_overflow    <= 1'b0;
    end else if (bus.rdy) begin
      r_upd_valid  <= w_pop;
      if (w_pop) begin
        r_upd_pc    <= w_head.pc;
        r_upd_taken <= w_head.taken;
      end
      r_mispredict <= w_mp0 | w_mp1;
      if (w_mp0)
        r_redirect_pc <= redirect_target(bus.c0_taken, bus.c0_pc, bus.c0_target);
      else if (w_mp1)
        r_redirect_pc <= redirect_target(bus.c1_taken, bus.c1_pc, bus.c1_target);
      r_br_count <= r_br_count + 32'(w_att0) + 32'(w_att1);
      if (w_mp0 | w_mp1) r_mp_count <= r_mp_count + 32'd1;
      if ((w_att0 | w_att1) & ~w_commit_ready) r_overflow <= 1'b1;
    end
  end

  assign bus.commit_ready = w_commit_ready;
  assign bus.upd_valid    = r_upd_valid;
  assign bus.upd_pc       = r_upd_pc;
  assign bus.upd_taken    = r_upd_taken;
  assign bus.mispredict   = r_mispredict;
  assign bus.redirect_pc  = r_redirect_pc;
  assign bus.br_count     = r_br_count;
  assign bus.mp_count     = r_mp_count;
  assign bus.overflow     = r_overflow;
endmodule

// File: doc/bht_update_queue.md
Name: bht_update_queue

Overview:
- Producer side of the branch-predictor update interface.
- Takes up to two in-order ROB commits per cycle and keeps only conditional branches.
- Detects mispredictions against the prediction bit carried in the ROB, raises the front-end redirect, and queues resolved outcomes.
- Drains one {pc, taken} update per cycle to the 2-bit-counter BHT, which always accepts.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4
PTR_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
rdy  in  1  global enable; when 0 the block freezes
c0_valid  in  1  commit lane 0 valid (older instruction)
c0_is_br  in  1  lane 0 is a conditional branch
c0_pc  in  32  lane 0 instruction PC
c0_taken  in  1  lane 0 resolved outcome, 1 = taken
c0_pred  in  1  lane 0 predicted outcome at fetch
c0_target  in  32  lane 0 taken target
c1_valid/c1_is_br/c1_pc/c1_taken/c1_pred/c1_target  in  1/1/32/1/1/32  commit lane 1 (younger), same meanings as lane 0
commit_ready  out  1  1 when at least 2 slots are free
upd_valid  out  1  update valid to BHT
upd_pc  out  32  update PC (BHT indexes pc[8:2])
upd_taken  out  1  resolved outcome
mispredict  out  1  one-cycle redirect pulse
redirect_pc  out  32  correct next PC
br_count  out  32  committed branches, wraps
mp_count  out  32  mispredictions, wraps
overflow  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at a posedge, regardless of rdy):
  - Queue emptied, pointers and count set to 0.
  - upd_valid=0, upd_pc=0, upd_taken=0, mispredict=0, redirect_pc=0, br_count=0, mp_count=0, overflow=0.
  - Reset has priority over every other event. In-flight entries are lost.
- rdy=0: no push, no pop. All registers and outputs hold their values, including a pending mispredict pulse.
- Lane qualification: a lane pushes only if valid & is_br & rdy & !rst.
- Push order: lane 0 before lane 1.
- Lane 1 kill: if lane 0 pushes and mispredicts (c0_taken != c0_pred), lane 1 is wrong-path and is fully ignored that cycle (no push, no count, no mispredict).
- Lane 1 alone: c1_valid with c0_valid=0 is legal and pushes into the next slot.
- Entry format: {pc[31:0], taken}, stored in a circular buffer.
- Write pointer advances by 0, 1 or 2; read pointer advances by 0 or 1. Both wrap modulo DEPTH.
- Drain:
  - Each rdy cycle with the queue non-empty, pop the head.
  - The head is presented on upd_valid/upd_pc/upd_taken as registered outputs, valid for exactly one cycle per entry.
  - An entry pushed at edge N is on the outputs no earlier than after edge N+1 (2-cycle minimum push-to-BHT latency).
  - With the queue empty, upd_valid=0 and upd_pc/upd_taken hold their last values.
- Count: count_next = count + pushes − pop, with simultaneous push and pop in the same cycle allowed.
- commit_ready = (DEPTH − count) >= 2. It is computed from the registered count and is not combinationally dependent on c*_valid.
- Overflow:
  - A push attempted while commit_ready=0 is a protocol violation: the entry is dropped and overflow is set (sticky until reset).
  - Pointers and count never exceed DEPTH.
- Mispredict:
  - Registered, one-cycle pulse in the cycle after the qualifying commit edge.
  - The oldest mispredicting lane wins.
  - redirect_pc = taken ? target : pc + 4, 32-bit wrap.
  - Back-to-back mispredicts on consecutive cycles produce consecutive pulses.
- Counters:
  - br_count increments by the number of pushed (or overflow-dropped) branches.
  - mp_count increments by 1 per mispredict pulse.
  - Both wrap modulo 2^32.

Decomposition:
- Shared package/const header: the `BR_ENTRY_W = 33` width constant and the BHT index field range 8:2.
- One natural sub-module, `dual_push_fifo` (2-write/1-read circular buffer with count), parameterised by DEPTH and entry width.
- Misprediction/redirect logic and the counters stay in the top level.

Test Plan:
- Single taken branch: c0 {pc=0x100, taken=1, pred=1} → after 2 edges upd_valid=1, upd_pc=0x100, upd_taken=1; mispredict stays 0; br_count=1.
- Lane-0 mispredict with younger lane: c0 {pc=0x200, taken=1, pred=0, target=0x340} plus c1 branch at 0x204 → mispredict=1 and redirect_pc=0x340 next cycle; only 0x200 enqueued; br_count=1, mp_count=1.
- Fill/backpressure: DEPTH=8, dual branch commits every cycle → commit_ready drops at count=7; 3 pushes of 2 plus 1 drain per cycle stay consistent; BHT sees PCs in exact commit order; overflow=0.
- Wrap-around with simultaneous push/pop: 20 sequential branches (pc=0x0,0x4,…) one per cycle → 20 updates in order, count never exceeds 1, pointers wrap cleanly.
- rdy stall: assert rdy=0 for 3 cycles with entries queued and a pending mispredict pulse → all outputs frozen; ordering and pulse resume unchanged after rdy=1.
- Reset mid-operation with 5 queued entries → next cycle upd_valid=0, commit_ready=1, counters=0, overflow=0; the subsequent branch drains normally.
